// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative multiply / signed-divide engine with its sequencing
//               FSM (IDLE -> CALC -> DONE). One bit per cycle, WIDTH
//               iterations, one-cycle alu_valid completion pulse.
//               Optional macro MULDIV_EARLY_OUT_EN: trivial operations
//               (MUL by zero, DIV by zero) skip CALC and finish in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [4:0] FUNC_MUL = 5'b00010,
    parameter logic [4:0] FUNC_DIV = 5'b00011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_start,
    input  logic [4:0]       alu_func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             alu_valid,
    output logic [WIDTH-1:0] result
);

    localparam int            c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operation context captured at the accepting edge
    logic             r_is_div;
    logic             r_neg;      // quotient must be negated
    logic             r_dz;       // divisor was zero
    logic [c_CW-1:0]  r_cnt;
    // MUL: r_a = shifted multiplicand, r_b = shifted multiplier, r_acc = partial product
    // DIV: r_a = dividend shifting out / quotient shifting in, r_b = divisor, r_acc = remainder
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_accept;
    logic             w_early;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_prod_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_final;

    assign w_is_mul = (alu_func == FUNC_MUL);
    assign w_is_div = (alu_func == FUNC_DIV);
    // Start is honoured only when the state register itself is IDLE
    assign w_accept = (r_state == S_IDLE) && alu_start && (w_is_mul || w_is_div);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = (w_is_mul && ((op_a == '0) || (op_b == '0))) ||
                     (w_is_div && (op_b == '0));
`else
    assign w_early = 1'b0;
`endif

    assign w_abs_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign w_abs_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

    // Shift-add step: add the multiplicand when the current multiplier bit is set
    assign w_prod_nxt = r_acc + (r_b[0] ? r_a : '0);

    // Restoring-division step: trial subtract, keep result if non-negative
    assign w_rem_sh  = {r_acc, r_a[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_rem_nxt = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {r_a[WIDTH-2:0], ~w_diff[WIDTH]};

    // Divide-by-zero forces all ones irrespective of the dividend sign;
    // most-negative / -1 naturally wraps back to the most-negative value.
    assign w_final = !r_is_div ? w_prod_nxt :
                     r_dz      ? {WIDTH{1'b1}} :
                     r_neg     ? (~w_quo_nxt + 1'b1) : w_quo_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        alu_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_early ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                alu_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-cycle iteration and result write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= w_is_div;
                        r_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_dz     <= (op_b == '0);
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_a      <= w_is_div ? w_abs_a : op_a;
                        r_b      <= w_is_div ? w_abs_b : op_b;
                        if (w_early) begin
                            result <= w_is_div ? {WIDTH{1'b1}} : '0;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_rem_nxt;
                        r_a   <= w_quo_nxt;
                    end else begin
                        r_acc <= w_prod_nxt;
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                        r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    end
                    if (r_cnt == c_LAST) begin
                        result <= w_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer: vector table,
//               hand-written busy/ignore/reset sequences, and random
//               operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_sequencer;

    localparam logic [4:0] FUNC_MUL = 5'b00010;
    localparam logic [4:0] FUNC_DIV = 5'b00011;
    localparam int         FULL_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_start;
    logic [4:0]  alu_func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        alu_valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          early;
        string       nm;
    } vec_t;

    vec_t tbl[13];

    muldiv_sequencer #(
        .WIDTH   (32),
        .FUNC_MUL(FUNC_MUL),
        .FUNC_DIV(FUNC_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_start(alu_start),
        .alu_func (alu_func),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .alu_valid(alu_valid),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: low WIDTH bits of the product; signed quotient truncated
    // toward zero computed in 64-bit arithmetic; divide by zero gives all ones.
    function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        if (f == FUNC_MUL) begin
            p = {32'd0, a} * {32'd0, b};
            return p[31:0];
        end
        if (b == 32'd0) return 32'hFFFF_FFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        return q[31:0];
    endfunction

    // Drive a one-cycle start; returns at the negedge just after the sampling edge
    task automatic start_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        alu_start = 1'b1;
        alu_func  = f;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        alu_start = 1'b0;
        alu_func  = 5'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
    endtask

    // Full operation: latency, result, busy and single-cycle valid
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string nm);
        int lat;
        start_op(f, a, b);
        chk({nm, " busy_first"}, {31'd0, busy}, 32'd1);
        lat = 1;
        while (!alu_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " valid_seen"}, {31'd0, alu_valid}, 32'd1);
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " busy_at_valid"}, {31'd0, busy}, 32'd1);
        chk({nm, " result"}, result, exp);
        @(negedge clk);
        chk({nm, " valid_one_cycle"}, {31'd0, alu_valid}, 32'd0);
        chk({nm, " busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          vcnt;
        logic [31:0] res;
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        bit          early;

        tbl[0]  = '{FUNC_MUL, 32'd7,          32'd6,          32'd42,         1'b0, "mul_7x6"};
        tbl[1]  = '{FUNC_DIV, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA, 1'b0, "div_m20_3"};
        tbl[2]  = '{FUNC_DIV, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, "div_20_m3"};
        tbl[3]  = '{FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf"};
        tbl[4]  = '{FUNC_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, "div_5_0"};
        tbl[5]  = '{FUNC_DIV, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 1'b1, "div_m5_0"};
        tbl[6]  = '{FUNC_MUL, 32'd0,          32'd9,          32'd0,          1'b1, "mul_0x9"};
        tbl[7]  = '{FUNC_MUL, 32'd3,          32'd5,          32'd15,         1'b0, "mul_3x5"};
        tbl[8]  = '{FUNC_DIV, 32'd100,        32'd7,          32'd14,         1'b0, "div_100_7"};
        tbl[9]  = '{FUNC_MUL, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFF1, 1'b0, "mul_m3x5"};
        tbl[10] = '{FUNC_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,          1'b0, "mul_wrap"};
        tbl[11] = '{FUNC_DIV, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, "div_7_m1"};
        tbl[12] = '{FUNC_DIV, 32'h8000_0000, 32'd1,          32'h8000_0000, 1'b0, "div_mn_1"};

        rst       = 1'b1;
        alu_start = 1'b0;
        alu_func  = 5'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset valid", {31'd0, alu_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table; consecutive entries start in the first IDLE cycle after valid
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp,
                   (tbl[i].early && EO) ? 1 : FULL_LAT, tbl[i].nm);
        end

        // Starts during CALC and in the DONE cycle must both be ignored
        start_op(FUNC_MUL, 32'd3, 32'd4);
        vcnt = 0;
        res  = 32'd0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 10) begin
                alu_start = 1'b1;
                alu_func  = FUNC_DIV;
                op_a      = 32'd99;
                op_b      = 32'd7;
            end else begin
                alu_start = 1'b0;
            end
            if (alu_valid) begin
                vcnt++;
                res       = result;
                alu_start = 1'b1;
                alu_func  = FUNC_MUL;
                op_a      = 32'd5;
                op_b      = 32'd5;
            end
            @(negedge clk);
        end
        alu_start = 1'b0;
        chk("busy_ignore valid_count", vcnt, 1);
        chk("busy_ignore result", res, 32'd12);
        chk("done_start ignored busy", {31'd0, busy}, 32'd0);
        chk("done_start ignored result", result, 32'd12);

        // Non-MUL/DIV function code in IDLE
        start_op(5'b00000, 32'd1, 32'd1);
        vcnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (busy || alu_valid) vcnt++;
            @(negedge clk);
        end
        chk("func0 no activity", vcnt, 0);
        chk("func0 result held", result, 32'd12);

        // Reset in the middle of a divide
        start_op(FUNC_DIV, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort valid", {31'd0, alu_valid}, 32'd0);
        rst  = 1'b0;
        vcnt = 0;
        for (int n = 0; n < 50; n++) begin
            if (alu_valid) vcnt++;
            @(negedge clk);
        end
        chk("abort no valid", vcnt, 0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f = ($urandom_range(0, 1) == 0) ? FUNC_MUL : FUNC_DIV;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: a = 32'd0;
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            early = (f == FUNC_MUL) ? ((a == 32'd0) || (b == 32'd0)) : (b == 32'd0);
            run_op(f, a, b, model(f, a, b), (early && EO) ? 1 : FULL_LAT,
                   $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide engine and its sequencing FSM, shared by the multi-cycle core's R-type path.
- Accepts a one-cycle `alu_start` pulse with operands and a 5-bit ALU function code, then iterates one bit per cycle.
- Reports completion with a one-cycle `alu_valid` pulse, which the control unit waits on before register writeback.
- Codes other than MUL/DIV are ignored, because the control unit pulses `alu_start` for every R-type instruction.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥ 4).
- FUNC_MUL, 5'b00010, ALU function code selecting multiply.
- FUNC_DIV, 5'b00011, ALU function code selecting signed divide.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_start  in  1  start pulse; sampled only in IDLE.
- alu_func  in  5  operation code; sampled with alu_start.
- op_a  in  WIDTH  multiplicand / dividend; sampled with alu_start.
- op_b  in  WIDTH  multiplier / divisor; sampled with alu_start.
- busy  out  1  high in CALC and DONE.
- alu_valid  out  1  one-cycle completion pulse; high only in DONE.
- result  out  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (port rst, clock port clk). State = IDLE; busy, alu_valid and result = 0; iteration counter = 0.
- FSM states are IDLE, CALC and DONE.
- IDLE -> CALC: taken when alu_start=1 and alu_func ∈ {FUNC_MUL, FUNC_DIV}.
  - Latch operands and op kind; clear the accumulator/remainder; counter = 0.
  - For DIV, latch |op_a|, |op_b| and quotient sign = sign(a) XOR sign(b).
- alu_start with any other alu_func: no state change, no alu_valid, result unchanged.
- CALC: one iteration per cycle; counter increments 0..WIDTH-1.
  - At the edge where counter == WIDTH-1: write the final result to `result` and go to DONE.
- DONE: alu_valid=1 for exactly one cycle, then unconditional transition to IDLE.
- Latency: start sampled at edge E0; alu_valid is high in the cycle following edge E0+WIDTH. For WIDTH=32, that is 33 cycles after the start cycle.
- alu_start during CALC or DONE is ignored; the in-flight operation is unaffected.
  - A start in the same cycle DONE exits is also ignored. Start is accepted only when the state register equals IDLE.
- MUL: shift-add, keeping only the low WIDTH bits of the product. Sign-agnostic: the low bits are identical for signed and unsigned.
- DIV: restoring division on magnitudes, producing a quotient truncated toward zero.
  - If the quotient sign is negative, the result is the two's complement of the magnitude quotient.
  - Remainder is computed internally but not output.
- Divide by zero: result = all ones (0xFFFFFFFF at WIDTH=32), regardless of dividend sign. Full latency applies unless the optional feature below is enabled.
- Overflow, most-negative / -1: result = most-negative value (0x80000000). No flag.
- rst during CALC or DONE: abort immediately, return to IDLE, clear outputs. No alu_valid for the aborted operation.
- `result` changes only at the final-iteration edge (or early-out edge) and on reset.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: at the accepting edge, the FSM goes straight to DONE (bypassing CALC) in these cases:
  - MUL with op_a==0 or op_b==0: result=0.
  - DIV with op_b==0: result=all ones.
  - In both cases alu_valid is high in the cycle immediately after the start cycle (latency 1).
- Not defined: no bypass. Every accepted operation takes the full WIDTH+1 latency; results are identical.

Test Plan:
- MUL 7×6 at WIDTH=32: start at cycle 0 -> alu_valid high at cycle 33 only; result=42; busy high cycles 1–33.
- DIV -20/3 -> result=0xFFFFFFFA (-6). DIV 20/-3 -> 0xFFFFFFFA. DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- DIV 5/0 -> result=0xFFFFFFFF. Latency 33 without MULDIV_EARLY_OUT_EN, 1 with it. MUL 0×9 -> 0, with the same latency split.
- Busy/ignore cases:
  - Second alu_start with different operands at cycle 10 of an in-flight MUL 3×4 -> one alu_valid only, result=12.
  - alu_start with alu_func=5'b00000 in IDLE -> busy stays 0, no alu_valid, result unchanged.
- Back-to-back: start MUL 3×5, then in the first IDLE cycle after valid start DIV 100/7 -> results 15 then 14. Each alu_valid is exactly one cycle.
- rst asserted at cycle 15 of a DIV -> next cycle state IDLE, busy=0, result=0, and no alu_valid ever for that operation.
